nibble_add_seq: RTL and testbench
=================================

NIBBLE_ADD_SEQ -- requirements
Module: nibble_add_seq

Interface
REQ-001 Parameter NIBBLES, default 4, number of 4-bit slices; operand width W = 4*NIBBLES; legal range 2..8.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 in_valid  input  1  operand request valid.
REQ-005 in_ready  output  1  block can accept a request.
REQ-006 a  input  W  operand A, unsigned/two's-complement.
REQ-007 b  input  W  operand B.
REQ-008 sub  input  1  0 = A+B, 1 = A-B.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 sum  output  W  result.
REQ-012 cout  output  1  carry out of MSB (for sub: 1 = no borrow).
REQ-013 ovfl  output  1  signed overflow of the W-bit operation.

Function
REQ-014 Block SHALL contain exactly one instance of the existing 4-bit CLA (ports A, B, CIN, SUM, COUT, OVFL), reused once per nibble, LSB nibble first.
REQ-015 FSM SHALL have states IDLE, RUN, DONE; encoding free.
REQ-016 IDLE: in_ready=1, out_valid=0; on in_valid=1 at an edge, capture a, b XOR {W{sub}}, carry register <= sub, nibble index <= 0, go to RUN.
REQ-017 in_ready SHALL be 1 only in IDLE; in_valid in RUN/DONE SHALL be ignored and operands not re-sampled.
REQ-018 RUN: each cycle CLA SHALL be driven with nibble[idx] of captured A and B and CIN = carry register; at the edge, SUM written to result nibble[idx], carry <= COUT, idx <= idx+1.
REQ-019 On the edge processing idx = NIBBLES-1: cout <= COUT, ovfl <= OVFL of that nibble, go to DONE.
REQ-020 Latency: request accepted at edge N SHALL give out_valid=1 after edge N+NIBBLES (4 cycles at default).
REQ-021 DONE: out_valid=1; sum, cout, ovfl SHALL remain stable until handshake; out_valid&out_ready at an edge SHALL return to IDLE.
REQ-022 Back-to-back: minimum spacing between accepted requests is NIBBLES+2 cycles; no IDLE-bypass from DONE.
REQ-023 Arithmetic SHALL equal (A + (sub ? ~B : B) + sub) mod 2^W; cout = bit W of that sum; ovfl = carry into MSB XOR carry out of MSB.
REQ-024 Outputs sum, cout, ovfl SHALL hold last result after leaving DONE until the next result is written (partial nibbles may update sum during RUN; consumers only sample in DONE).
REQ-025 Nibble index SHALL not wrap past NIBBLES-1; no state reachable other than the three listed; illegal encoding SHALL recover to IDLE.

Reset
REQ-026 rst_n=0 at an edge SHALL force IDLE, in_ready=1 (after reset), out_valid=0, sum=0, cout=0, ovfl=0, idx=0, carry=0, from any state including mid-RUN.
REQ-027 Request presented in the same cycle rst_n=0 SHALL be dropped.
REQ-028 No result for an operation interrupted by reset SHALL ever be presented.

Verification
REQ-029 Add: a=0x1234, b=0x0FFF, sub=0 -> after 4 cycles sum=0x2233, cout=0, ovfl=0, out_valid=1.
REQ-030 Overflow/carry: 0x7FFF+0x0001 -> 0x8000, cout=0, ovfl=1; 0xFFFF+0x0001 -> 0x0000, cout=1, ovfl=0.
REQ-031 Subtract: 0x0005-0x0007 -> 0xFFFE, cout=0, ovfl=0; 0x8000-0x0001 -> 0x7FFF, cout=1, ovfl=1.
REQ-032 Backpressure: hold out_ready=0 for 3 cycles in DONE while toggling in_valid and operands -> out_valid, sum, cout, ovfl unchanged, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-033 Reset mid-RUN: assert rst_n=0 after 2 nibbles processed -> next cycle all outputs 0, in_ready=1; new request 0x0001+0x0001 -> 0x0002 with no carry leakage.
REQ-034 Random: 500 random (a, b, sub) with random out_ready stalls -> every result matches REQ-023 reference model and latency REQ-020.

Source files
------------

// File: rtl/nibble_add_seq_if.sv
// nibble_add_seq_if: request/result handshake bundle for the nibble-serial adder.
interface nibble_add_seq_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovfl;
    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovfl
    );
    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovfl
    );
endinterface

// File: rtl/nibble_add_seq.sv
// nibble_add_seq: W-bit add/subtract computed one nibble per cycle through a single 4-bit CLA.
module cla4 (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       CIN,
    output logic [3:0] SUM,
    output logic       COUT,
    output logic       OVFL
);
    logic [3:0] p, g;
    logic [4:0] c;
    assign p = A ^ B;
    assign g = A & B;
    assign c[0] = CIN;
    assign c[1] = g[0] | (p[0] & CIN);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & CIN);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & CIN);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & CIN);
    assign SUM  = p ^ c[3:0];
    assign COUT = c[4];
    assign OVFL = c[4] ^ c[3];
endmodule

module nibble_add_seq #(
    parameter int NIBBLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    nibble_add_seq_if.slave    bus
);
    localparam int W = 4 * NIBBLES;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t       state_q, state_d;
    logic [W-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [2:0]   idx_q, idx_d;
    logic         carry_q, carry_d, cout_q, cout_d, ovfl_q, ovfl_d;
    logic [3:0]   cla_sum;
    logic         cla_cout, cla_ovfl;
    cla4 u_cla (
        .A    (a_q[{idx_q, 2'b00} +: 4]),
        .B    (b_q[{idx_q, 2'b00} +: 4]),
        .CIN  (carry_q),
        .SUM  (cla_sum),
        .COUT (cla_cout),
        .OVFL (cla_ovfl)
    );
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovfl_d  = ovfl_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                // B is pre-inverted and carry seeded with sub so the datapath only ever adds
                a_d     = bus.a;
                b_d     = bus.b ^ {W{bus.sub}};
                carry_d = bus.sub;
                idx_d   = 3'd0;
                state_d = RUN;
            end
            RUN: begin
                sum_d[{idx_q, 2'b00} +: 4] = cla_sum;
                carry_d = cla_cout;
                if (idx_q >= 3'(NIBBLES - 1)) begin
                    cout_d  = cla_cout;
                    ovfl_d  = cla_ovfl;
                    idx_d   = 3'd0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 3'd1;
                end
            end
            DONE: if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovfl_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovfl_q  <= ovfl_d;
        end
    end
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovfl      = ovfl_q;
endmodule

// File: tb/tb_nibble_add_seq.sv
// tb_nibble_add_seq: table vectors, backpressure/reset sequences and random ops checked via a scoreboard queue.
module tb_nibble_add_seq;
    localparam int N = 4;
    localparam int W = 4 * N;
    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovfl;
    } vec_t;
    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovfl;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   acc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    vec_t tbl[8];
    nibble_add_seq_if #(.NIBBLES(N)) bus ();
    nibble_add_seq #(.NIBBLES(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic [W-1:0] low;
        exp_t e;
        bb   = s ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, s};
        low  = {1'b0, a[W-2:0]} + {1'b0, bb[W-2:0]} + {{(W-1){1'b0}}, s};
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovfl = full[W] ^ low[W-1];
        return e;
    endfunction
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input exp_t e);
        int g = 0;
        while (!bus.in_ready && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        check("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.sub = s;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        sb.push_back(e);
        acc = cyc;
    endtask
    task automatic collect(input int stall, input bit toggle);
        int g = 0;
        exp_t e;
        while (!bus.out_valid && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        check("out_valid_arrive", {31'd0, bus.out_valid}, 32'd1);
        check("latency", cyc - acc, N);
        e = sb.pop_front();
        for (int i = 0; i < stall; i++) begin
            if (toggle) begin
                bus.in_valid = ~bus.in_valid;
                bus.a = W'($urandom);
                bus.b = W'($urandom);
                bus.sub = 1'($urandom);
            end
            @(posedge clk); #1;
            if (toggle) begin
                check("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
                check("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
                check("stall_sum", 32'(bus.sum), 32'(e.sum));
                check("stall_cout", {31'd0, bus.cout}, {31'd0, e.cout});
                check("stall_ovfl", {31'd0, bus.ovfl}, {31'd0, e.ovfl});
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        check("sum", 32'(bus.sum), 32'(e.sum));
        check("cout", {31'd0, bus.cout}, {31'd0, e.cout});
        check("ovfl", {31'd0, bus.ovfl}, {31'd0, e.ovfl});
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check("post_hs_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("post_hs_in_ready", {31'd0, bus.in_ready}, 32'd1);
    endtask
    initial begin
        exp_t e;
        tbl[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0};
        tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[2] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[3] = '{16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tbl[4] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tbl[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[6] = '{16'h0000, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[7] = '{16'h00F0, 16'h0F10, 1'b0, 16'h1000, 1'b0, 1'b0};
        bus.in_valid = 1'b1;
        bus.a = 16'hAAAA;
        bus.b = 16'h5555;
        bus.sub = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        rst_n = 1'b1;
        check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_sum", 32'(bus.sum), 32'd0);
        check("rst_cout", {31'd0, bus.cout}, 32'd0);
        check("rst_ovfl", {31'd0, bus.ovfl}, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        check("dropped_req_no_result", {31'd0, bus.out_valid}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            issue(tbl[i].a, tbl[i].b, tbl[i].sub, '{tbl[i].sum, tbl[i].cout, tbl[i].ovfl});
            collect(i % 3, 1'b0);
        end
        issue(16'h0F0F, 16'h0101, 1'b1, '{16'h0E0E, 1'b1, 1'b0});
        collect(3, 1'b1);
        issue(16'hFFFF, 16'hFFFF, 1'b0, '{16'hFFFE, 1'b1, 1'b0});
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        check("midrun_in_ready", {31'd0, bus.in_ready}, 32'd1);
        check("midrun_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("midrun_sum", 32'(bus.sum), 32'd0);
        check("midrun_cout", {31'd0, bus.cout}, 32'd0);
        check("midrun_ovfl", {31'd0, bus.ovfl}, 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("midrun_no_result", {31'd0, bus.out_valid}, 32'd0);
        issue(16'h0001, 16'h0001, 1'b0, '{16'h0002, 1'b0, 1'b0});
        collect(0, 1'b0);
        for (int i = 0; i < 500; i++) begin
            logic [W-1:0] ra, rb;
            logic rs;
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            e = model(ra, rb, rs);
            issue(ra, rb, rs, e);
            collect(int'($urandom_range(0, 3)), 1'b0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
